axi_adapter_arbiter: RTL

- Shares one AXI adapter request port (req/type/addr/we/wdata/be/size/id, gnt, valid/rdata/id) among NR_PORTS cache-side requesters (e.g. icache refill, dcache miss unit, dcache bypass).
- Keeps at most one transaction in flight.
- Locks the owner from selection until the adapter's completion pulse.
- Stamps the adapter id with the owner index and steers the grant and response back to that owner only.

---
 rtl/axi_adapter_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axi_adapter_arbiter.sv
// axi_adapter_arbiter: shares one AXI adapter request port among NR_PORTS cache-side requesters.
// Latency: zero added cycles (request muxed combinationally in IDLE); grant/valid steered in the cycle they arrive.
// Backpressure: one transaction in flight; losers hold req_i. Macro AXI_ADAPTER_ARB_FIXED_PRIO_EN selects fixed priority.
package axi_adapter_arbiter_pkg;
    typedef enum logic { SINGLE_REQ = 1'b0, CACHE_LINE_REQ = 1'b1 } req_t;
endpackage

module axi_adapter_arbiter
    import axi_adapter_arbiter_pkg::*;
#(
    parameter int NR_PORTS     = 3,
    parameter int DATA_WIDTH   = 256,
    parameter int AXI_ID_WIDTH = 10
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NR_PORTS-1:0]                       req_i,
    input  req_t [NR_PORTS-1:0]                       type_i,
    input  logic [NR_PORTS-1:0][63:0]                 addr_i,
    input  logic [NR_PORTS-1:0]                       we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]       wdata_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]     be_i,
    input  logic [NR_PORTS-1:0][1:0]                  size_i,
    output logic [NR_PORTS-1:0]                       gnt_o,
    output logic [NR_PORTS-1:0]                       valid_o,
    output logic [DATA_WIDTH-1:0]                     rdata_o,
    output logic                                      adp_req_o,
    output req_t                                      adp_type_o,
    output logic [63:0]                               adp_addr_o,
    output logic                                      adp_we_o,
    output logic [DATA_WIDTH-1:0]                     adp_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                   adp_be_o,
    output logic [1:0]                                adp_size_o,
    output logic [AXI_ID_WIDTH-1:0]                   adp_id_o,
    input  logic                                      adp_gnt_i,
    input  logic                                      adp_valid_i,
    input  logic [DATA_WIDTH-1:0]                     adp_rdata_i,
    input  logic [AXI_ID_WIDTH-1:0]                   adp_id_i,
    output logic                                      id_err_o
);
    localparam int IDX_W = $clog2(NR_PORTS);

    typedef enum logic [1:0] { IDLE, LOCKED, WAIT_RESP } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        win;
    logic [IDX_W-1:0]        sel;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    id_err_q;
    logic                    resp_fire;
    logic                    unused_id_hi;

    // Only the low index bits of the response id carry the owner stamp.
    assign unused_id_hi = ^adp_id_i[AXI_ID_WIDTH-1:IDX_W];

    assign resp_fire = (state_q == WAIT_RESP) && adp_valid_i && !rst_i;

`ifdef AXI_ADAPTER_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        win = '0;
        for (int k = NR_PORTS - 1; k >= 0; k--) begin
            if (req_i[IDX_W'(k)]) win = IDX_W'(k);
        end
    end
`else
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Round-robin: scan from the pointer upward, wrapping at NR_PORTS.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NR_PORTS)) sum = sum - (IDX_W+1)'(NR_PORTS);
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Pointer moves just past the owner when its transaction completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          rr_q <= '0;
        else if (resp_fire) rr_q <= (owner_q == IDX_W'(NR_PORTS - 1)) ? '0 : owner_q + 1'b1;
    end
`endif

    // Before the lock is taken the fresh winner drives the adapter; afterwards the owner does.
    assign sel = (state_q == IDLE) ? win : owner_q;

    // Next-state and handshake steering; reset forces every handshake output low at once.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        adp_req_o = 1'b0;
        gnt_o     = '0;
        valid_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    adp_req_o = 1'b1;
                    owner_d   = win;
                    if (adp_gnt_i) begin
                        gnt_o[win] = 1'b1;
                        state_d    = WAIT_RESP;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Owner withdrawing before grant abandons the slot without touching the pointer.
                if (!req_i[owner_q]) begin
                    state_d = IDLE;
                end else begin
                    adp_req_o = 1'b1;
                    if (adp_gnt_i) begin
                        gnt_o[owner_q] = 1'b1;
                        state_d        = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (adp_valid_i) begin
                    valid_o[owner_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            adp_req_o = 1'b0;
            gnt_o     = '0;
            valid_o   = '0;
        end
    end

    // Request-field mux toward the adapter, zeroed while in reset.
    always_comb begin
        adp_type_o  = SINGLE_REQ;
        adp_addr_o  = '0;
        adp_we_o    = 1'b0;
        adp_wdata_o = '0;
        adp_be_o    = '0;
        adp_size_o  = '0;
        adp_id_o    = '0;
        if (!rst_i) begin
            adp_type_o            = type_i[sel];
            adp_addr_o            = addr_i[sel];
            adp_we_o              = we_i[sel];
            adp_wdata_o           = wdata_i[sel];
            adp_be_o              = be_i[sel];
            adp_size_o            = size_i[sel];
            adp_id_o[IDX_W-1:0]   = sel;
        end
    end

    // State, owner, held read data and the sticky id-mismatch flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rdata_q  <= '0;
            id_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (resp_fire) begin
                rdata_q <= adp_rdata_i;
                if (adp_id_i[IDX_W-1:0] != owner_q) id_err_q <= 1'b1;
            end
        end
    end

    assign rdata_o  = resp_fire ? adp_rdata_i : rdata_q;
    assign id_err_o = id_err_q;

endmodule
